// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM encoding
// and the width of one buffered command.
package alu_pkg;

    localparam int OPC_W  = 3;
    localparam int OPND_W = 16;

    localparam logic [OPC_W-1:0] OP_ADD   = 3'b000;
    localparam logic [OPC_W-1:0] OP_MUL   = 3'b001;
    localparam logic [OPC_W-1:0] OP_SUB   = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND   = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR   = 3'b100;
    localparam logic [OPC_W-1:0] OP_OR    = 3'b101;
    localparam logic [OPC_W-1:0] OP_PASSB = 3'b110;
    localparam logic [OPC_W-1:0] OP_NOT   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_t;

    // Command bundle layout, MSB first: {opcode, operand A, operand B, tag}.
    function automatic int cmd_bundle_w(input int tag_w);
        return OPC_W + 2 * OPND_W + tag_w;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pushes while full and pops while empty are
// ignored, so callers may drive push/pop from plain request signals.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = cmd_bundle_w(2)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage array; contents are only meaningful between wptr and rptr.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front end for the 16-bit ALU: queues tagged commands, issues them one at a
// time with a single-cycle enable, and returns each registered result with
// its tag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing in flight; pop the FIFO head as soon as one exists
//   ST_DRIVE | alu_en high for this one cycle; result captured at its end
//   ST_RESP  | rsp_valid high, result/tag held until rsp_ready
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_opcode,
    input  logic [15:0]        cmd_floatA,
    input  logic [15:0]        cmd_floatB,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic [15:0]        alu_floatA,
    output logic [15:0]        alu_floatB,
    output logic [2:0]         alu_opcode,
    output logic               alu_en,
    input  logic [15:0]        alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_result,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               busy
);

    localparam int BW = cmd_bundle_w(TAG_W);

    seq_state_t             state;
    logic [TAG_W-1:0]       issue_tag;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [BW-1:0]          fifo_rdata;
    logic [2:0]             head_op;
    logic [15:0]            head_a;
    logic [15:0]            head_b;
    logic [TAG_W-1:0]       head_tag;

    // cmd_ready comes only from the registered count, so a pop in a full
    // cycle frees the slot one cycle later.
    assign cmd_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);
    assign {head_op, head_a, head_b, head_tag} = fifo_rdata;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (BW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_opcode, cmd_floatA, cmd_floatB, cmd_tag}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pop the head whenever the FSM is about to enter DRIVE.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: fifo_pop = !fifo_empty;
            ST_RESP: fifo_pop = rsp_ready && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Issue/response FSM; all ALU-side and response outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            alu_en     <= 1'b0;
            alu_opcode <= 3'b000;
            alu_floatA <= 16'h0000;
            alu_floatB <= 16'h0000;
            issue_tag  <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_tag    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_opcode <= head_op;
                        alu_floatA <= head_a;
                        alu_floatB <= head_b;
                        issue_tag  <= head_tag;
                        alu_en     <= 1'b1;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // alu_result is only trusted here, while the ALU is enabled.
                    rsp_result <= alu_result;
                    rsp_tag    <= issue_tag;
                    rsp_valid  <= 1'b1;
                    alu_en     <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!fifo_empty) begin
                            alu_opcode <= head_op;
                            alu_floatA <= head_a;
                            alu_floatB <= head_b;
                            issue_tag  <= head_tag;
                            alu_en     <= 1'b1;
                            state      <= ST_DRIVE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    alu_en    <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU that floats its
// result while disabled.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_opcode = '0;
    logic [15:0]       cmd_floatA = '0;
    logic [15:0]       cmd_floatB = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic [15:0]       alu_floatA;
    logic [15:0]       alu_floatB;
    logic [2:0]        alu_opcode;
    logic              alu_en;
    wire  [15:0]       alu_result;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [15:0]       rsp_result;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0]      er [8];
    logic [TAG_W-1:0] et [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_floatA (cmd_floatA),
        .cmd_floatB (cmd_floatB),
        .cmd_tag    (cmd_tag),
        .alu_floatA (alu_floatA),
        .alu_floatB (alu_floatB),
        .alu_opcode (alu_opcode),
        .alu_en     (alu_en),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    // Behavioural ALU, result truncated to 16 bits, floating when disabled.
    logic [31:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (alu_opcode)
            OP_ADD:   alu_full = {16'h0, alu_floatA} + {16'h0, alu_floatB};
            OP_MUL:   alu_full = {16'h0, alu_floatA} * {16'h0, alu_floatB};
            OP_SUB:   alu_full = {16'h0, alu_floatA} - {16'h0, alu_floatB};
            OP_AND:   alu_full = {16'h0, alu_floatA & alu_floatB};
            OP_XOR:   alu_full = {16'h0, alu_floatA ^ alu_floatB};
            OP_OR:    alu_full = {16'h0, alu_floatA | alu_floatB};
            OP_PASSB: alu_full = {16'h0, alu_floatB};
            default:  alu_full = {16'h0, ~alu_floatA};
        endcase
    end
    assign alu_result = alu_en ? alu_full[15:0] : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called just after a rising edge; offers one command for one edge.
    task automatic try_push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [TAG_W-1:0] tag, output bit acc);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_floatA = a;
        cmd_floatB = b;
        cmd_tag    = tag;
        acc        = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic push_wait(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [TAG_W-1:0] tag);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) try_push(op, a, b, tag, acc);
        if (!acc) check("push_timeout", 32'd0, 32'd1);
    endtask

    // One command from an idle, empty block, checking cycle-exact timing.
    task automatic run_one(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [TAG_W-1:0] tag, input logic [15:0] exp);
        bit acc;
        rsp_ready = 1'b1;
        try_push(op, a, b, tag, acc);
        check("one_acc", {31'd0, acc}, 32'd1);
        @(negedge clk);
        check("one_en_c0", {31'd0, alu_en}, 32'd0);
        @(negedge clk);
        check("one_en_c1", {31'd0, alu_en}, 32'd1);
        check("one_opc", {29'd0, alu_opcode}, {29'd0, op});
        check("one_a", {16'd0, alu_floatA}, {16'd0, a});
        check("one_b", {16'd0, alu_floatB}, {16'd0, b});
        @(negedge clk);
        check("one_en_c2", {31'd0, alu_en}, 32'd0);
        check("one_rv", {31'd0, rsp_valid}, 32'd1);
        check("one_res", {16'd0, rsp_result}, {16'd0, exp});
        check("one_tag", {30'd0, rsp_tag}, {30'd0, tag});
        @(negedge clk);
        check("one_rv_done", {31'd0, rsp_valid}, 32'd0);
        check("one_busy_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Collect n responses against er/et; rsp_ready must already be high.
    task automatic collect(input int n, input bit spacing);
        int got;
        int last;
        got  = 0;
        last = 0;
        for (int budget = 0; budget < 200 && got < n; budget++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                check("col_res", {16'd0, rsp_result}, {16'd0, er[got]});
                check("col_tag", {30'd0, rsp_tag}, {30'd0, et[got]});
                check("col_noz", {31'd0, $isunknown(rsp_result)}, 32'd0);
                if (spacing && got > 0) check("col_spacing", cyc - last, 32'd2);
                last = cyc;
                got++;
            end
        end
        check("col_count", got, n);
    endtask

    initial begin
        bit acc;

        // Reset values
        #3;
        check("rst_alu_en", {31'd0, alu_en}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_a", {16'd0, alu_floatA}, 32'h0);
        check("rst_alu_b", {16'd0, alu_floatB}, 32'h0);
        check("rst_alu_op", {29'd0, alu_opcode}, 32'h0);
        check("rst_rsp_res", {16'd0, rsp_result}, 32'h0);
        check("rst_rsp_tag", {30'd0, rsp_tag}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single commands, including wrap and truncation cases
        run_one(OP_ADD,   16'h0003, 16'h0004, 2'd1, 16'h0007);
        run_one(OP_MUL,   16'h0100, 16'h0100, 2'd2, 16'h0000);
        run_one(OP_SUB,   16'h0001, 16'h0002, 2'd3, 16'hFFFF);
        run_one(OP_NOT,   16'h00FF, 16'h1234, 2'd0, 16'hFF00);
        run_one(OP_ADD,   16'hFFFF, 16'h0001, 2'd1, 16'h0000);
        run_one(OP_PASSB, 16'h1111, 16'hBEEF, 2'd2, 16'hBEEF);

        // Backpressure: DEPTH queued plus one in flight, then full
        rsp_ready = 1'b0;
        try_push(OP_ADD, 16'h0001, 16'h0001, 2'd1, acc); check("bp_acc0", {31'd0, acc}, 32'd1);
        try_push(OP_ADD, 16'h00FF, 16'h0001, 2'd2, acc); check("bp_acc1", {31'd0, acc}, 32'd1);
        try_push(OP_SUB, 16'h0010, 16'h0001, 2'd3, acc); check("bp_acc2", {31'd0, acc}, 32'd1);
        try_push(OP_XOR, 16'hAAAA, 16'hFFFF, 2'd0, acc); check("bp_acc3", {31'd0, acc}, 32'd1);
        try_push(OP_MUL, 16'h0003, 16'h0007, 2'd1, acc); check("bp_acc4", {31'd0, acc}, 32'd1);
        check("bp_ready_full", {31'd0, cmd_ready}, 32'd0);
        try_push(OP_OR, 16'h0F0F, 16'hF0F0, 2'd2, acc); check("bp_acc5", {31'd0, acc}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_en_low", {31'd0, alu_en}, 32'd0);
            check("bp_rv", {31'd0, rsp_valid}, 32'd1);
            check("bp_res_hold", {16'd0, rsp_result}, 32'h0002);
            check("bp_tag_hold", {30'd0, rsp_tag}, 32'd1);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        er[0] = 16'h0002; et[0] = 2'd1;
        er[1] = 16'h0100; et[1] = 2'd2;
        er[2] = 16'h000F; et[2] = 2'd3;
        er[3] = 16'h5555; et[3] = 2'd0;
        er[4] = 16'h0015; et[4] = 2'd1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        collect(5, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained_busy", {31'd0, busy}, 32'd0);
        check("bp_drained_ready", {31'd0, cmd_ready}, 32'd1);

        // Back-to-back stream with concurrent push and pop
        er[0] = 16'h1234; et[0] = 2'd0;
        er[1] = 16'hF0F0; et[1] = 2'd1;
        er[2] = 16'h3030; et[2] = 2'd2;
        er[3] = 16'h0FF0; et[3] = 2'd3;
        er[4] = 16'hBEEF; et[4] = 2'd0;
        er[5] = 16'h0120; et[5] = 2'd1;
        er[6] = 16'h0FFF; et[6] = 2'd2;
        er[7] = 16'hAAAA; et[7] = 2'd3;
        rsp_ready = 1'b1;
        fork
            begin
                push_wait(OP_ADD,   16'h1000, 16'h0234, 2'd0);
                push_wait(OP_XOR,   16'hFF00, 16'h0FF0, 2'd1);
                push_wait(OP_AND,   16'hF0F0, 16'h3C3C, 2'd2);
                push_wait(OP_OR,    16'h0F00, 16'h00F0, 2'd3);
                push_wait(OP_PASSB, 16'h1111, 16'hBEEF, 2'd0);
                push_wait(OP_MUL,   16'h0012, 16'h0010, 2'd1);
                push_wait(OP_SUB,   16'h1000, 16'h0001, 2'd2);
                push_wait(OP_NOT,   16'h5555, 16'h0000, 2'd3);
            end
            collect(8, 1'b1);
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset while a command is in DRIVE with three more queued
        rsp_ready = 1'b1;
        try_push(OP_ADD, 16'h0001, 16'h0002, 2'd0, acc);
        try_push(OP_ADD, 16'h0003, 16'h0004, 2'd1, acc);
        try_push(OP_ADD, 16'h0005, 16'h0006, 2'd2, acc);
        try_push(OP_ADD, 16'h0007, 16'h0008, 2'd3, acc);
        try_push(OP_ADD, 16'h0009, 16'h000A, 2'd0, acc);
        try_push(OP_ADD, 16'h000B, 16'h000C, 2'd1, acc);
        check("mr_in_drive", {31'd0, alu_en}, 32'd1);
        check("mr_drive_a", {16'd0, alu_floatA}, 32'h0005);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_alu_en", {31'd0, alu_en}, 32'd0);
        check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mr_rsp_res", {16'd0, rsp_result}, 32'h0);
        check("mr_alu_a", {16'd0, alu_floatA}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mr_no_stale_rv", {31'd0, rsp_valid}, 32'd0);
            check("mr_no_stale_en", {31'd0, alu_en}, 32'd0);
            check("mr_idle_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk);
        #1;
        run_one(OP_XOR, 16'h00F0, 16'h0FF0, 2'd3, 16'h0F00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Initiator-side front end for the 16-bit ALU. Accepts tagged commands (opcode, operand A, operand B) on a valid/ready port and buffers them in a small FIFO. Issues one command at a time to the ALU by driving the ALU's operand, opcode and enable inputs for exactly one cycle. Registers the ALU result and returns it with its tag on a valid/ready response port.

## Interface
- `DEPTH`, 4: command FIFO entries; must be a power of two, ≥2.
- `TAG_W`, 2: width of the opaque command tag returned with each result.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_opcode`  in  3  ALU opcode: 000 add, 001 mul, 010 sub, 011 and, 100 xor, 101 or, 110 pass B, 111 not A.
- `cmd_floatA`  in  16  operand A.
- `cmd_floatB`  in  16  operand B.
- `cmd_tag`  in  TAG_W  tag.
- `alu_floatA`  out  16  to ALU operand A.
- `alu_floatB`  out  16  to ALU operand B.
- `alu_opcode`  out  3  to ALU opcode.
- `alu_en`  out  1  ALU enable.
- `alu_result`  in  16  from ALU; combinational; high-Z while `alu_en`=0.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_result`  out  16  captured ALU result.
- `rsp_tag`  out  TAG_W  tag of that command.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- A push occurs when `cmd_valid` && `cmd_ready`. `cmd_ready` is derived from the registered full flag only.
  - When full, a same-cycle pop does not open `cmd_ready` that cycle.
- Push and pop in the same non-full cycle are both performed; the count is unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the issue registers (opcode, A, B, tag) and go to DRIVE. Otherwise stay.
  - DRIVE: `alu_en`=1 with the issue registers on the `alu_*` outputs. At the clock edge, capture `alu_result` into `rsp_result` and the tag into `rsp_tag`, then go to RESP.
  - RESP: `rsp_valid`=1 and `rsp_result`/`rsp_tag` are held stable. On `rsp_ready`:
    - if the FIFO is non-empty, pop and go to DRIVE;
    - otherwise go to IDLE.
    - Without `rsp_ready`, stay in RESP.
- `alu_result` is sampled only in DRIVE, so the high-Z value is never captured.
- `alu_floatA`/`alu_floatB`/`alu_opcode` hold their last issued values outside DRIVE.
- Results are whatever the ALU returns, truncated to 16 bits. The sequencer performs no arithmetic and no flagging.
- Commands complete strictly in FIFO order.
- FIFO occupancy counter width is clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
- Reset (async assert, any state):
  - FSM goes to IDLE and the FIFO is emptied; in-flight and queued commands are discarded.
  - `alu_en`=0, `rsp_valid`=0, `cmd_ready`=1, `busy`=0.
  - `alu_floatA`/`alu_floatB`/`rsp_result`=16'h0000, `alu_opcode`=3'b000, `rsp_tag`=0.

## Timing
- Command accepted at edge N → head of FIFO at N+1 → DRIVE during cycle N+1…N+2 → `rsp_valid` high after edge N+2. Accept-to-response latency is 2 cycles from an empty, idle block.
- `alu_en` is high for exactly one cycle per command.
- Sustained throughput with `rsp_ready`=1: one response every 2 cycles (DRIVE, RESP alternating).
- Maximum outstanding commands: DEPTH queued plus one in DRIVE/RESP.
- All outputs are registered, except `cmd_ready` (from the registered full flag) and `busy` (from registered state).

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams OP_ADD…OP_NOT;
  - FSM state encoding (IDLE, DRIVE, RESP);
  - the command bundle width (3+16+16+TAG_W).
- One sub-module: `alu_cmd_fifo`, a synchronous DEPTH×bundle FIFO with push/pop, full/empty and count, and async active-low reset.
- The ALU is instantiated outside this block, at the parent.

## Test plan
- Single add: cmd 000, A=0x0003, B=0x0004, tag 1; `rsp_ready`=1 → `alu_en` pulses one cycle; `rsp_valid` after 2 cycles with result 0x0007, tag 1.
- Wrap/truncation: mul 0x0100×0x0100 → 0x0000. Sub 0x0001−0x0002 → 0xFFFF. Not A=0x00FF → 0xFF00.
- Backpressure/full with `rsp_ready`=0, DEPTH=4: 5 commands accepted, `cmd_ready` low on the 6th. `rsp_result` is held stable and `alu_en` stays low while stalled. Releasing `rsp_ready` drains tags in order.
- Back-to-back: 8 commands (tags 0,1,2,3,0,1,2,3) with `rsp_ready`=1 → responses every 2 cycles in order; push and pop coincide without loss.
- Reset mid-DRIVE with 3 queued → next cycle: `alu_en`=0, `rsp_valid`=0, `busy`=0, `cmd_ready`=1. No stale response ever appears.
- Z-safety: the ALU model drives `alu_result`=Z when disabled → `rsp_result` never contains X/Z bits.
